// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: hit/writeback/fill FSM driving the PLRU update port; CACHE_PERF_CNT_EN adds hit/miss/writeback counters
module cache_miss_ctrl #(
  parameter int s_index  = 3,
  parameter int width    = 1,
  parameter int s_offset = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic [width-1:0] hit_way,
  input  logic             victim_valid,
  input  logic             victim_dirty,
  output logic             lru_read,
  input  logic [width-1:0] evict_ways,
  output logic             lru_load,
  output logic [width-1:0] lru_hit_ways,
  output logic [width-1:0] way_sel,
  output logic             addr_sel,
  output logic             data_load,
  output logic             fill_sel,
  output logic             tag_load,
  output logic             valid_set,
  output logic             dirty_set,
  output logic             dirty_clr,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count,
  output logic [31:0]      wb_count
`endif
);
  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
  state_t state, state_n;
  logic [width-1:0] victim_q;
  logic req, miss;
  assign req  = mem_read | mem_write;
  assign miss = state == CHECK && req && !hit;
  if (s_index < 1 || s_offset < 0 || width < 1) begin : g_bad_cfg
    $error("cache_miss_ctrl: invalid parameters");
  end
  always_comb begin
    state_n      = state;
    mem_resp     = 1'b0;
    lru_read     = 1'b0;
    lru_load     = 1'b0;
    lru_hit_ways = '0;
    way_sel      = '0;
    addr_sel     = 1'b0;
    data_load    = 1'b0;
    fill_sel     = 1'b0;
    tag_load     = 1'b0;
    valid_set    = 1'b0;
    dirty_set    = 1'b0;
    dirty_clr    = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    case (state)
      IDLE: state_n = req ? CHECK : IDLE;
      CHECK: begin
        lru_read = 1'b1;
        if (!req) state_n = IDLE;
        else if (hit) begin
          mem_resp     = 1'b1;
          lru_load     = 1'b1;
          lru_hit_ways = hit_way;
          way_sel      = hit_way;
          data_load    = mem_write;
          dirty_set    = mem_write;
          state_n      = IDLE;
        end else begin
          way_sel = evict_ways;
          state_n = victim_valid && victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        way_sel    = victim_q;
        addr_sel   = 1'b1;
        pmem_write = 1'b1;
        dirty_clr  = pmem_resp;
        state_n    = pmem_resp ? FILL : WRITEBACK;
      end
      FILL: begin
        way_sel   = victim_q;
        pmem_read = 1'b1;
        data_load = pmem_resp;
        fill_sel  = pmem_resp;
        tag_load  = pmem_resp;
        valid_set = pmem_resp;
        dirty_clr = pmem_resp;
        state_n   = pmem_resp ? CHECK : FILL;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      victim_q <= '0;
    end else begin
      state    <= state_n;
      victim_q <= miss ? evict_ways : victim_q;
    end
  end
`ifdef CACHE_PERF_CNT_EN
  logic from_fill;
  always_ff @(posedge clk) begin
    if (rst) begin
      from_fill  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      from_fill <= state == FILL;
      if (state == CHECK && req && hit && !from_fill && hit_count != '1) hit_count <= hit_count + 1;
      if (miss && miss_count != '1) miss_count <= miss_count + 1;
      if (miss && state_n == WRITEBACK && wb_count != '1) wb_count <= wb_count + 1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: directed checks of hits, clean/dirty misses, reset and dropped requests
module tb_cache_miss_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0, victim_valid = 1'b0, victim_dirty = 1'b0, pmem_resp = 1'b0;
  logic [0:0] hit_way = '0, evict_ways = '0;
  logic mem_resp, lru_read, lru_load, addr_sel, data_load, fill_sel, tag_load, valid_set, dirty_set, dirty_clr, pmem_read, pmem_write;
  logic [0:0] lru_hit_ways, way_sel;
  logic [13:0] outs;
  int checks = 0, failures = 0;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif
  cache_miss_ctrl #(.s_index(3), .width(1), .s_offset(5)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .hit_way(hit_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .lru_read(lru_read), .evict_ways(evict_ways), .lru_load(lru_load), .lru_hit_ways(lru_hit_ways),
    .way_sel(way_sel), .addr_sel(addr_sel), .data_load(data_load), .fill_sel(fill_sel),
    .tag_load(tag_load), .valid_set(valid_set), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );
  assign outs = {mem_resp, lru_read, lru_load, lru_hit_ways, way_sel, addr_sel, data_load,
                 fill_sel, tag_load, valid_set, dirty_set, dirty_clr, pmem_read, pmem_write};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic idle_in();
    mem_read = 0; mem_write = 0; hit = 0; hit_way = 0; evict_ways = 0;
    victim_valid = 0; victim_dirty = 0; pmem_resp = 0;
  endtask
  task automatic do_hit(input logic wr, input logic [0:0] w);
    mem_write = wr; mem_read = !wr; hit = 1; hit_way = w;
    tick(); #1;
  endtask
  task automatic dirty_miss();
    mem_read = 1; hit = 0; evict_ways = 1; victim_valid = 1; victim_dirty = 1;
    tick(); #1;
    chk("dm_check_way", way_sel, 1);
    tick(); evict_ways = 0; #1;
    chk("dm_wb_pmem_write", pmem_write, 1);
    chk("dm_wb_addr_sel", addr_sel, 1);
    chk("dm_wb_way_held", way_sel, 1);
    chk("dm_wb_no_clr", dirty_clr, 0);
    tick(); tick(); pmem_resp = 1; #1;
    chk("dm_wb_dirty_clr", dirty_clr, 1);
    tick(); pmem_resp = 0; #1;
    chk("dm_fill_pmem_read", {pmem_read, pmem_write, addr_sel}, 3'b100);
    chk("dm_fill_way_held", way_sel, 1);
    tick(); pmem_resp = 1; #1;
    chk("dm_fill_strobes", {data_load, fill_sel, tag_load, valid_set, dirty_clr}, 5'b11111);
    tick(); pmem_resp = 0; hit = 1; hit_way = 1; #1;
    chk("dm_recheck_resp", {mem_resp, lru_load, lru_hit_ways}, 3'b111);
    idle_in();
  endtask
  initial begin
    tick(); tick();
    rst = 0; #1;
    chk("reset_outs", outs, 0);
    // read hit on way 1
    mem_read = 1; hit = 1; hit_way = 1; #1;
    chk("rh_idle_no_resp", mem_resp, 0);
    tick(); #1;
    chk("rh_resp_lru", {mem_resp, lru_read, lru_load, lru_hit_ways, way_sel}, 5'b11111);
    chk("rh_no_write", {data_load, dirty_set}, 0);
    idle_in(); tick(); #1;
    chk("rh_back_idle", outs, 0);
    // clean miss on way 0
    mem_read = 1; evict_ways = 0; victim_valid = 1;
    tick(); #1;
    chk("cm_check", {mem_resp, lru_read, lru_load}, 3'b010);
    tick(); #1;
    chk("cm_fill", {pmem_read, pmem_write, addr_sel, way_sel, tag_load}, 5'b10000);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("cm_fill_held", pmem_read, 1);
    end
    pmem_resp = 1; #1;
    chk("cm_fill_strobes", {data_load, fill_sel, tag_load, valid_set, dirty_clr, dirty_set}, 6'b111110);
    tick(); pmem_resp = 0; hit = 1; hit_way = 0; #1;
    chk("cm_recheck_resp", {mem_resp, lru_load, lru_hit_ways}, 3'b110);
    idle_in(); tick();
    dirty_miss();
    tick(); #1;
    chk("dm_idle", outs, 0);
    // write hit on way 0, then read+write together on way 1
    do_hit(1, 0);
    chk("wh_strobes", {mem_resp, lru_load, lru_hit_ways, data_load, fill_sel, dirty_set}, 6'b110101);
    idle_in(); tick();
    mem_read = 1; mem_write = 1; hit = 1; hit_way = 1;
    tick(); #1;
    chk("rw_is_write", {data_load, dirty_set, fill_sel, mem_resp}, 4'b1101);
    idle_in(); tick();
    // reset during writeback, then stray pmem_resp in idle
    mem_read = 1; evict_ways = 1; victim_valid = 1; victim_dirty = 1;
    tick(); tick(); #1;
    chk("rst_pre_wb", pmem_write, 1);
    rst = 1; tick(); rst = 0; idle_in(); #1;
    chk("rst_outs", outs, 0);
    pmem_resp = 1; tick(); #1;
    chk("stray_resp_idle", outs, 0);
    tick(); pmem_resp = 0; #1;
    chk("stray_resp_still_idle", outs, 0);
    // invalid-but-dirty victim skips writeback; request dropped mid-fill
    mem_read = 1; victim_valid = 0; victim_dirty = 1;
    tick(); tick(); #1;
    chk("inv_dirty_fill", {pmem_read, pmem_write}, 2'b10);
    mem_read = 0; pmem_resp = 1;
    tick(); pmem_resp = 0; #1;
    chk("drop_recheck", {lru_read, mem_resp, lru_load}, 3'b100);
    tick(); #1;
    chk("drop_idle", outs, 0);
`ifdef CACHE_PERF_CNT_EN
    idle_in(); rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      do_hit(0, 1'(i));
      idle_in(); tick();
    end
    dirty_miss();
    tick(); #1;
    chk("perf_hit", hit_count, 3);
    chk("perf_miss", miss_count, 1);
    chk("perf_wb", wb_count, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Cache control FSM that consumes the tree-PLRU victim output and drives the PLRU hit-update port.
Sits between the CPU-side cache request port, the cache datapath (tag/valid/dirty/data arrays), the PLRU, and the physical-memory port.
- On a hit, it completes the request and promotes the hit way.
- On a miss, it takes the PLRU victim, writes it back if it is dirty, fills the line, then re-checks the request.

Parameters:
s_index, 3, number of set-index bits (matches the PLRU and the arrays)
width, 1, log2(number of ways); num_ways = 2**width
s_offset, 5, line-offset bits; pmem_address low s_offset bits are always 0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  one-cycle request completion
hit  in  1  datapath: tag match on a valid way for the current request
hit_way  in  width  datapath: way that matched
victim_valid  in  1  valid bit of the way selected by way_sel
victim_dirty  in  1  dirty bit of the way selected by way_sel
lru_read  out  1  enable PLRU evict_ways output
evict_ways  in  width  PLRU victim way
lru_load  out  1  PLRU update strobe
lru_hit_ways  out  width  way to promote in the PLRU
way_sel  out  width  way addressed by the datapath
addr_sel  out  1  0 = pmem address from request tag; 1 = from way_sel's stored tag
data_load  out  1  write data array (line fill or CPU write)
fill_sel  out  1  1 = data_load source is pmem line; 0 = CPU write data
tag_load  out  1  write tag array at way_sel
valid_set  out  1  set valid bit at way_sel
dirty_set  out  1  set dirty bit at way_sel
dirty_clr  out  1  clear dirty bit at way_sel
pmem_read  out  1  physical memory line read, held until pmem_resp
pmem_write  out  1  physical memory line write, held until pmem_resp
pmem_resp  in  1  physical memory completion, one cycle

Behaviour:
- States: IDLE, CHECK, WRITEBACK, FILL.
- Outputs are a combinational decode of the state and the registered victim_q.
- In the first cycle after rst every output is 0 and the FSM is in IDLE; victim_q resets to 0.

IDLE:
- All outputs 0.
- Goes to CHECK when mem_read or mem_write is 1.

CHECK:
- lru_read=1.
- On hit:
  - mem_resp=1, lru_load=1, lru_hit_ways=hit_way, way_sel=hit_way.
  - If mem_write: data_load=1, fill_sel=0, dirty_set=1.
  - Next state IDLE.
- On miss:
  - way_sel=evict_ways; victim_q<=evict_ways.
  - If victim_valid and victim_dirty, next state WRITEBACK; otherwise next state FILL.

WRITEBACK:
- way_sel=victim_q, addr_sel=1, pmem_write=1.
- On pmem_resp: dirty_clr=1, next state FILL.

FILL:
- way_sel=victim_q, addr_sel=0, pmem_read=1.
- On pmem_resp: data_load=1, fill_sel=1, tag_load=1, valid_set=1, dirty_clr=1; next state CHECK.
- The re-check then hits.

Timing:
- Hit latency: request seen in IDLE, mem_resp in the following CHECK cycle (2 cycles).
- Clean-miss latency: CHECK + FILL (waiting on memory) + CHECK.
- lru_load is asserted only in a hit CHECK cycle, so every completed access promotes exactly once.

Boundary conditions:
- mem_read and mem_write both 1: treated as a write.
- pmem_resp in IDLE or CHECK: ignored.
- Request dropped mid-miss: protocol violation. The FSM still finishes the WRITEBACK/FILL sequence, then returns to CHECK and, finding no request, to IDLE with mem_resp=0.
- rst in any state: next cycle is IDLE with all strobes 0. An in-flight pmem transaction is abandoned; memory is reset by the same rst.
- Victim invalid but dirty: no writeback.
- width=1: evict_ways is 1 bit. No special casing for other widths.

Optional Feature:
Macro CACHE_PERF_CNT_EN.
- Defined: adds outputs hit_count, miss_count, wb_count, each 32 bits.
  - hit_count increments on a hit CHECK that was not entered from FILL.
  - miss_count increments on a miss CHECK.
  - wb_count increments on entry to WRITEBACK.
  - All counters saturate at 32'hFFFFFFFF and reset to 0.
- Not defined: the ports and the logic are absent; all other behaviour is identical.

Test Plan:
- Read hit, way 1: mem_read=1, hit=1, hit_way=1 -> in the CHECK cycle mem_resp=1, lru_load=1, lru_hit_ways=1; back in IDLE next cycle.
- Clean miss: hit=0, evict_ways=0, victim_valid=1, victim_dirty=0 -> FILL with way_sel=0, pmem_read held; pmem_resp after 5 cycles -> tag_load, valid_set, data_load, fill_sel=1; re-CHECK with hit=1 -> mem_resp.
- Dirty miss: evict_ways=1, victim_dirty=1 -> WRITEBACK, addr_sel=1, pmem_write=1 until pmem_resp -> dirty_clr, then FILL -> completes; victim_q stays 1 even if evict_ways changes to 0 mid-miss.
- Write hit: mem_write=1, hit=1, hit_way=0 -> data_load=1, fill_sel=0, dirty_set=1, mem_resp=1, lru_hit_ways=0.
- Reset mid-WRITEBACK: rst=1 for one cycle -> next cycle all outputs 0, IDLE; a stray pmem_resp in IDLE causes no transition.
- CACHE_PERF_CNT_EN: 3 hits + 1 dirty miss -> hit_count=3, miss_count=1, wb_count=1.
